// File: rtl/ks_lfsr_gen_if.sv
// Keystream word stream between ks_lfsr_gen and the downstream XOR combiner.
//   ks       : 16-bit keystream word, stable while ks_valid=1
//   ks_valid : ks holds a complete word
//   ks_ready : downstream accepts ks this cycle
interface ks_lfsr_gen_if;
    logic [15:0] ks;
    logic        ks_valid;
    logic        ks_ready;

    modport master (output ks, output ks_valid, input ks_ready);
    modport slave  (input ks, input ks_valid, output ks_ready);
endinterface

// File: rtl/ks_lfsr_gen.sv
// Bit-serial 16-bit Fibonacci LFSR keystream generator
// (x^16+x^14+x^13+x^11+1).
// It steps one bit per clock and packs 16 output bits MSB-first into a word.
// Each word is offered on a valid/ready stream.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin continuous word generation (IDLE only)
//   stop     : finish after the current word is accepted (FILL/HOLD)
//   seed_we  : load seed into the LFSR (IDLE only); zero seed -> SEED_DEFAULT
//   seed     : seed value
//   busy     : state is not IDLE
//   ks_o     : keystream stream (master side)
module ks_lfsr_gen #(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 seed_we,
    input  logic [15:0]          seed,
    output logic                 busy,
    ks_lfsr_gen_if.master        ks_o
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] s_q, s_d;
    logic [15:0] sh_q, sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        stop_q, stop_d;
    logic [15:0] ks_q, ks_d;
    logic        ks_valid_q, ks_valid_d;

    logic        fb;
    logic [15:0] sh_next;

    assign fb      = s_q[15] ^ s_q[13] ^ s_q[12] ^ s_q[10];
    assign sh_next = {sh_q[14:0], s_q[15]};

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        stop_d     = stop_q;
        ks_d       = ks_q;
        ks_valid_d = ks_valid_q;
        unique case (state_q)
            IDLE: begin
                // A seed load and start in the same cycle both take effect;
                // the first FILL step then sees the new seed.
                if (seed_we) s_d = (seed == 16'h0000) ? SEED_DEFAULT : seed;
                if (start) begin
                    state_d = FILL;
                    cnt_d   = 4'd0;
                    stop_d  = 1'b0;
                end
            end
            FILL: begin
                s_d   = {s_q[14:0], fb};
                sh_d  = sh_next;
                cnt_d = cnt_q + 4'd1;
                if (stop) stop_d = 1'b1;
                if (cnt_q == 4'd15) begin
                    ks_d       = sh_next;
                    ks_valid_d = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (stop) stop_d = 1'b1;
                if (ks_valid_q && ks_o.ks_ready) begin
                    ks_valid_d = 1'b0;
                    if (stop_q || stop) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FILL;
                        cnt_d   = 4'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= SEED_DEFAULT;
            sh_q       <= 16'h0000;
            cnt_q      <= 4'd0;
            stop_q     <= 1'b0;
            ks_q       <= 16'h0000;
            ks_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            stop_q     <= stop_d;
            ks_q       <= ks_d;
            ks_valid_q <= ks_valid_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign ks_o.ks       = ks_q;
    assign ks_o.ks_valid = ks_valid_q;

endmodule
